// File: rtl/time_keeper.sv
// Calendar and time-of-day counter advanced once per clk1sec edge, with Gregorian
// leap years, a clamped synchronous preset and a one-second midnight tick.
module time_keeper #(
    parameter logic [11:0] RST_YEAR = 12'd2021,
    parameter logic [2:0]  RST_WEEK = 3'd5
) (
    input  logic        clk1sec,
    input  logic        rst,
    input  logic        run,
    input  logic        set_en,
    input  logic [11:0] set_year,
    input  logic [7:0]  set_month,
    input  logic [7:0]  set_day,
    input  logic [7:0]  set_hour,
    input  logic [7:0]  set_minute,
    input  logic [7:0]  set_second,
    input  logic [2:0]  set_week,
    output logic [11:0] year,
    output logic [7:0]  month,
    output logic [7:0]  day,
    output logic [7:0]  hour,
    output logic [7:0]  minute,
    output logic [7:0]  second,
    output logic [2:0]  week,
    output logic        leap_year,
    output logic [4:0]  max_date,
    output logic        day_tick
);

    logic [11:0] r_year;
    logic [7:0]  r_month;
    logic [7:0]  r_day;
    logic [7:0]  r_hour;
    logic [7:0]  r_minute;
    logic [7:0]  r_second;
    logic [2:0]  r_week;
    logic        r_dayTick;

    function automatic logic isLeap(input logic [11:0] y);
        return ((y[1:0] == 2'b00) && ((y % 12'd100) != 12'd0)) || ((y % 12'd400) == 12'd0);
    endfunction

    function automatic logic [4:0] daysInMonth(input logic [7:0] m, input logic leap);
        case (m)
            8'd1, 8'd3, 8'd5, 8'd7, 8'd8, 8'd10, 8'd12: return 5'd31;
            8'd4, 8'd6, 8'd9, 8'd11:                    return 5'd30;
            8'd2:                                       return leap ? 5'd29 : 5'd28;
            default:                                    return 5'd0;
        endcase
    endfunction

    logic       w_leap;
    logic [4:0] w_maxDate;

    assign w_leap    = isLeap(r_year);
    assign w_maxDate = daysInMonth(r_month, w_leap);

    // Preset clamping; the day limit uses the already-clamped month.
    logic [7:0] w_setMonth;
    logic [7:0] w_setDay;
    logic [7:0] w_setHour;
    logic [7:0] w_setMinute;
    logic [7:0] w_setSecond;
    logic [2:0] w_setWeek;
    logic [4:0] w_setMax;

    always_comb begin
        w_setMonth  = set_month;
        w_setDay    = set_day;
        w_setHour   = set_hour;
        w_setMinute = set_minute;
        w_setSecond = set_second;
        w_setWeek   = set_week;
        if (set_month == 8'd0 || set_month > 8'd12) w_setMonth = 8'd1;
        w_setMax = daysInMonth(w_setMonth, isLeap(set_year));
        if (set_day == 8'd0)
            w_setDay = 8'd1;
        else if (set_day > {3'b000, w_setMax})
            w_setDay = {3'b000, w_setMax};
        if (set_hour > 8'd23)   w_setHour   = 8'd0;
        if (set_minute > 8'd59) w_setMinute = 8'd0;
        if (set_second > 8'd59) w_setSecond = 8'd0;
        if (set_week > 3'd6)    w_setWeek   = 3'd0;
    end

    logic w_secWrap;
    logic w_minWrap;
    logic w_hourWrap;
    logic w_hourCarry;
    logic w_dayCarry;
    logic w_monthCarry;
    logic w_yearCarry;

    assign w_secWrap    = r_second >= 8'd59;
    assign w_minWrap    = r_minute >= 8'd59;
    assign w_hourWrap   = r_hour >= 8'd23;
    assign w_hourCarry  = w_secWrap & w_minWrap;
    assign w_dayCarry   = w_hourCarry & w_hourWrap;
    assign w_monthCarry = w_dayCarry & (r_day >= {3'b000, w_maxDate});
    assign w_yearCarry  = w_monthCarry & (r_month >= 8'd12);

    always_ff @(posedge clk1sec or negedge rst) begin
        if (!rst) begin
            r_year    <= RST_YEAR;
            r_month   <= 8'd1;
            r_day     <= 8'd1;
            r_hour    <= 8'd0;
            r_minute  <= 8'd0;
            r_second  <= 8'd0;
            r_week    <= RST_WEEK;
            r_dayTick <= 1'b0;
        end else if (set_en) begin
            r_year    <= set_year;
            r_month   <= w_setMonth;
            r_day     <= w_setDay;
            r_hour    <= w_setHour;
            r_minute  <= w_setMinute;
            r_second  <= w_setSecond;
            r_week    <= w_setWeek;
            r_dayTick <= 1'b0;
        end else if (run) begin
            r_second  <= w_secWrap ? 8'd0 : r_second + 8'd1;
            r_dayTick <= w_dayCarry;
            if (w_secWrap)
                r_minute <= w_minWrap ? 8'd0 : r_minute + 8'd1;
            if (w_hourCarry)
                r_hour <= w_hourWrap ? 8'd0 : r_hour + 8'd1;
            if (w_dayCarry) begin
                r_day  <= w_monthCarry ? 8'd1 : r_day + 8'd1;
                r_week <= (r_week >= 3'd6) ? 3'd0 : r_week + 3'd1;
            end
            if (w_monthCarry)
                r_month <= w_yearCarry ? 8'd1 : r_month + 8'd1;
            // 12-bit add wraps 4095 to 0 on its own.
            if (w_yearCarry)
                r_year <= r_year + 12'd1;
        end
    end

    assign year      = r_year;
    assign month     = r_month;
    assign day       = r_day;
    assign hour      = r_hour;
    assign minute    = r_minute;
    assign second    = r_second;
    assign week      = r_week;
    assign day_tick  = r_dayTick;
    assign leap_year = w_leap;
    assign max_date  = w_maxDate;

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: directed calendar corner cases followed by randomized
// run/load traffic, all compared against a seconds-of-day calendar model.
module tb_time_keeper;

    logic        clk1sec;
    logic        rst;
    logic        run;
    logic        set_en;
    logic [11:0] set_year;
    logic [7:0]  set_month;
    logic [7:0]  set_day;
    logic [7:0]  set_hour;
    logic [7:0]  set_minute;
    logic [7:0]  set_second;
    logic [2:0]  set_week;
    logic [11:0] year;
    logic [7:0]  month;
    logic [7:0]  day;
    logic [7:0]  hour;
    logic [7:0]  minute;
    logic [7:0]  second;
    logic [2:0]  week;
    logic        leap_year;
    logic [4:0]  max_date;
    logic        day_tick;

    int checks = 0;
    int errors = 0;

    int mYear, mMonth, mDay, mHour, mMinute, mSecond, mWeek, mTick;

    time_keeper #(.RST_YEAR(12'd2021), .RST_WEEK(3'd5)) dut (
        .clk1sec(clk1sec), .rst(rst), .run(run), .set_en(set_en),
        .set_year(set_year), .set_month(set_month), .set_day(set_day),
        .set_hour(set_hour), .set_minute(set_minute), .set_second(set_second),
        .set_week(set_week), .year(year), .month(month), .day(day),
        .hour(hour), .minute(minute), .second(second), .week(week),
        .leap_year(leap_year), .max_date(max_date), .day_tick(day_tick)
    );

    initial clk1sec = 1'b0;
    always #5 clk1sec = ~clk1sec;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int mLeap(input int y);
        return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0) ? 1 : 0;
    endfunction

    function automatic int mDays(input int mo, input int y);
        int table31[13] = '{0, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (mo < 1 || mo > 12) return 0;
        if (mo == 2) return 28 + mLeap(y);
        return table31[mo];
    endfunction

    task automatic modelReset();
        mYear = 2021; mMonth = 1; mDay = 1;
        mHour = 0; mMinute = 0; mSecond = 0;
        mWeek = 5; mTick = 0;
    endtask

    task automatic modelLoad(input int y, input int mo, input int d, input int h,
                             input int mi, input int s, input int w);
        mYear   = y % 4096;
        mMonth  = (mo < 1 || mo > 12) ? 1 : mo;
        mDay    = (d < 1) ? 1 : ((d > mDays(mMonth, mYear)) ? mDays(mMonth, mYear) : d);
        mHour   = (h > 23) ? 0 : h;
        mMinute = (mi > 59) ? 0 : mi;
        mSecond = (s > 59) ? 0 : s;
        mWeek   = (w > 6) ? 0 : w;
        mTick   = 0;
    endtask

    task automatic modelCount();
        int secs;
        secs  = mHour * 3600 + mMinute * 60 + mSecond + 1;
        mTick = 0;
        if (secs == 86400) begin
            secs  = 0;
            mTick = 1;
            mWeek = (mWeek + 1) % 7;
            if (mDay >= mDays(mMonth, mYear)) begin
                mDay = 1;
                if (mMonth == 12) begin
                    mMonth = 1;
                    mYear  = (mYear + 1) % 4096;
                end else begin
                    mMonth++;
                end
            end else begin
                mDay++;
            end
        end
        mHour   = secs / 3600;
        mMinute = (secs / 60) % 60;
        mSecond = secs % 60;
    endtask

    task automatic compareAll(input string tag);
        checkOutput({tag, ".year"},   int'(year),      mYear);
        checkOutput({tag, ".month"},  int'(month),     mMonth);
        checkOutput({tag, ".day"},    int'(day),       mDay);
        checkOutput({tag, ".hour"},   int'(hour),      mHour);
        checkOutput({tag, ".minute"}, int'(minute),    mMinute);
        checkOutput({tag, ".second"}, int'(second),    mSecond);
        checkOutput({tag, ".week"},   int'(week),      mWeek);
        checkOutput({tag, ".tick"},   int'(day_tick),  mTick);
        checkOutput({tag, ".leap"},   int'(leap_year), mLeap(mYear));
        checkOutput({tag, ".max"},    int'(max_date),  mDays(mMonth, mYear));
    endtask

    // Drive one edge worth of inputs, let the edge happen, update the model, compare.
    task automatic applyStimulus(input string tag, input bit r, input bit se,
                                 input int y, input int mo, input int d, input int h,
                                 input int mi, input int s, input int w);
        run        = r;
        set_en     = se;
        set_year   = 12'(y);
        set_month  = 8'(mo);
        set_day    = 8'(d);
        set_hour   = 8'(h);
        set_minute = 8'(mi);
        set_second = 8'(s);
        set_week   = 3'(w);
        @(posedge clk1sec);
        #1;
        if (se)     modelLoad(y, mo, d, h, mi, s, w);
        else if (r) modelCount();
        compareAll(tag);
    endtask

    task automatic countEdge(input string tag);
        applyStimulus(tag, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b0; run = 1'b0; set_en = 1'b0;
        set_year = '0; set_month = '0; set_day = '0; set_hour = '0;
        set_minute = '0; set_second = '0; set_week = '0;
        modelReset();
        repeat (2) @(posedge clk1sec);
        #1;
        compareAll("reset");
        checkOutput("reset.maxConst", int'(max_date), 31);
        rst = 1'b1;

        // First edge after release increments from the reset values.
        countEdge("postReset");
        checkOutput("postReset.secConst", int'(second), 1);

        applyStimulus("leapLoad", 1'b0, 1'b1, 2024, 2, 28, 23, 59, 59, 3);
        countEdge("leapFeb29");
        checkOutput("leapFeb29.dayConst", int'(day), 29);
        checkOutput("leapFeb29.tickConst", int'(day_tick), 1);
        countEdge("leapAfterTick");
        applyStimulus("leap29Load", 1'b0, 1'b1, 2024, 2, 29, 23, 59, 59, 4);
        countEdge("leapMar1");
        checkOutput("leapMar1.monthConst", int'(month), 3);

        applyStimulus("c2100Load", 1'b0, 1'b1, 2100, 2, 28, 23, 59, 59, 0);
        countEdge("c2100");
        checkOutput("c2100.monthConst", int'(month), 3);
        applyStimulus("c2000Load", 1'b0, 1'b1, 2000, 2, 28, 23, 59, 59, 1);
        countEdge("c2000");
        checkOutput("c2000.leapConst", int'(leap_year), 1);

        applyStimulus("y4095Load", 1'b0, 1'b1, 4095, 12, 31, 23, 59, 59, 6);
        countEdge("y4095Wrap");
        checkOutput("y4095Wrap.yearConst", int'(year), 0);
        checkOutput("y4095Wrap.weekConst", int'(week), 0);
        applyStimulus("y2021Load", 1'b0, 1'b1, 2021, 12, 31, 23, 59, 59, 5);
        countEdge("y2022");

        applyStimulus("clampAll", 1'b0, 1'b1, 2023, 13, 40, 30, 61, 99, 7);
        checkOutput("clampAll.dayConst", int'(day), 31);
        applyStimulus("clampFeb", 1'b0, 1'b1, 2023, 2, 30, 10, 10, 10, 2);
        checkOutput("clampFeb.dayConst", int'(day), 28);
        applyStimulus("clampDay0", 1'b0, 1'b1, 2023, 0, 0, 12, 0, 0, 3);

        // Hold with day_tick high, then load while running at :59.
        applyStimulus("holdLoad", 1'b0, 1'b1, 2022, 6, 30, 23, 59, 59, 2);
        countEdge("holdTick");
        for (int i = 0; i < 5; i++) applyStimulus("hold", 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("prio", 1'b1, 1'b1, 2030, 5, 15, 8, 30, 59, 1);
        checkOutput("prio.secConst", int'(second), 59);

        // Asynchronous reset between edges, then reset colliding with a load.
        @(posedge clk1sec);
        #3 rst = 1'b0;
        #1;
        modelReset();
        compareAll("asyncRst");
        #1 rst = 1'b1;
        countEdge("asyncRelease");
        set_en = 1'b1; set_year = 12'd1999; set_month = 8'd7;
        rst = 1'b0;
        @(posedge clk1sec);
        #1;
        modelReset();
        compareAll("rstOverLoad");
        rst = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            bit r, se;
            r  = ($urandom_range(0, 3) != 0);
            se = ($urandom_range(0, 9) == 0);
            applyStimulus("rand", r, se,
                          int'($urandom_range(0, 4095)), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 40)), int'($urandom_range(20, 31)),
                          int'($urandom_range(56, 63)), int'($urandom_range(50, 99)),
                          int'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
